// File: rtl/s2p_frame_ctrl.sv
// Sequencer for the s2p shifter: hunts for SYNC_WORD, slices the payload into BIT-bit words and hands them out
// through a one-entry valid/ready buffer. Optional hunt timeout is built when S2P_FRAME_CTRL_TIMEOUT_EN is defined.
module s2p_frame_ctrl #(
   parameter int               BIT          = 10,
   parameter logic [BIT-1:0]   SYNC_WORD    = 10'b1011001101,
   parameter int               FRAME_WORDS  = 4,
   parameter int               HUNT_TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   output logic           s2p_en,
   input  logic [BIT-1:0] s2p_dout,
   output logic [BIT-1:0] word_data,
   output logic           word_valid,
   input  logic           word_ready,
   output logic           word_last,
   output logic           locked,
   output logic           busy,
   output logic           overflow,
   output logic           timeout
);

   localparam int             CW     = $clog2(BIT + 1);
   localparam logic [CW-1:0]  BIT_C  = CW'(BIT);
   localparam logic [CW-1:0]  ONE_C  = CW'(1);
   localparam logic [7:0]     LAST_W = 8'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {IDLE, HUNT, COLLECT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   fill_q, fill_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      wcnt_q, wcnt_d;
   logic            en_q, en_d;
   logic [BIT-1:0]  data_q, data_d;
   logic            valid_q, valid_d;
   logic            last_q, last_d;
   logic            ovf_q, ovf_d;
   logic            capture, xfer;

`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
   localparam int             HW        = $clog2(HUNT_TIMEOUT + 1);
   localparam logic [HW-1:0]  HUNT_LAST = HW'(HUNT_TIMEOUT - 1);
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic            tmo_q, tmo_d;
`endif

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      capture = 1'b0;
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
      hcnt_d  = hcnt_q;
      tmo_d   = tmo_q;
`endif
      xfer = valid_q & word_ready;

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = HUNT;
                  fill_d  = '0;
                  ovf_d   = 1'b0;
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
                  tmo_d   = 1'b0;
                  hcnt_d  = '0;
`endif
               end
            end
            HUNT: begin
               if (fill_q != BIT_C) fill_d = fill_q + 1'b1;
               // a match needs BIT shifts since entry so stale shifter contents never qualify
               if (fill_q == BIT_C && s2p_dout == SYNC_WORD) begin
                  state_d = COLLECT;
                  cnt_d   = ONE_C;
                  wcnt_d  = '0;
               end
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
               else if (hcnt_q == HUNT_LAST) begin
                  state_d = IDLE;
                  tmo_d   = 1'b1;
               end
               hcnt_d = hcnt_q + 1'b1;
`endif
            end
            COLLECT: begin
               if (cnt_q == BIT_C) begin
                  capture = 1'b1;
                  cnt_d   = ONE_C;
                  wcnt_d  = wcnt_q + 1'b1;
                  if (wcnt_q == LAST_W) state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // a word that finds the buffer occupied and not draining is dropped, but still counts toward the frame
      if (capture && valid_q && !word_ready) begin
         ovf_d = 1'b1;
      end else if (capture) begin
         data_d  = s2p_dout;
         valid_d = 1'b1;
         last_d  = (wcnt_q == LAST_W);
      end else if (xfer) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      en_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         fill_q  <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         en_q    <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
         hcnt_q  <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         en_q    <= en_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
         hcnt_q  <= hcnt_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign s2p_en     = en_q;
   assign word_data  = data_q;
   assign word_valid = valid_q;
   assign word_last  = last_q;
   assign overflow   = ovf_q;
   assign locked     = (state_q == COLLECT);
   assign busy       = (state_q != IDLE);
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
   assign timeout    = tmo_q;
`else
   assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: emulates the s2p shifter, compares every cycle against a bit-stream reference model,
// and pins the model with directed literal expectations.
module tb_s2p_frame_ctrl;
   localparam int BIT = 10;
   localparam int FW  = 4;
   localparam int HT  = 64;
   localparam logic [BIT-1:0] SYNC = 10'b1011001101;
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, start, abort, word_ready;
   logic s2p_en, word_valid, word_last, locked, busy, overflow, timeout;
   logic [BIT-1:0] word_data;
   logic [BIT-1:0] sr = '0;

   s2p_frame_ctrl #(.BIT(BIT), .SYNC_WORD(SYNC), .FRAME_WORDS(FW), .HUNT_TIMEOUT(HT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .s2p_en(s2p_en), .s2p_dout(sr),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
      .locked(locked), .busy(busy), .overflow(overflow), .timeout(timeout));

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   logic stream[$];
   logic hist[$];
   logic [BIT-1:0] got_d[$];
   logic got_l[$];
   int got_c[$];

   // reference model state
   bit m_ok = 0;
   int m_mode = 0;                 // 0 idle, 1 hunt, 2 collect
   int m_ncol, m_words, m_hunt;
   logic m_vld, m_lst, m_ovf, m_tmo;
   logic [BIT-1:0] m_dat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [BIT-1:0] window();
      logic [BIT-1:0] w;
      for (int i = 0; i < BIT; i++) w[BIT-1-i] = hist[hist.size()-BIT+i];
      return w;
   endfunction

   // shifter emulation plus reference model, both advanced on the rising edge
   initial forever begin
      logic b, xfer, cap;
      int nxt;
      @(posedge clk);
      cyc++;
      b = (stream.size() != 0) ? stream[0] : 1'b0;
      if (s2p_en) begin
         sr <= {sr[BIT-2:0], b};
         if (stream.size() != 0) void'(stream.pop_front());
      end
      if (word_valid && word_ready) begin
         got_d.push_back(word_data); got_l.push_back(word_last); got_c.push_back(cyc);
      end
      if (rst) begin
         m_ok = 1; m_mode = 0; m_vld = 0; m_lst = 0; m_dat = '0; m_ovf = 0; m_tmo = 0;
      end else if (m_ok) begin
         xfer = m_vld && word_ready;
         cap = 0;
         nxt = m_mode;
         if (abort) nxt = 0;
         else if (m_mode == 0) begin
            if (start) begin nxt = 1; hist.delete(); m_ovf = 0; m_tmo = 0; m_hunt = 0; end
         end else if (m_mode == 1) begin
            if (hist.size() >= BIT && window() == SYNC) begin nxt = 2; m_ncol = 0; m_words = 0; end
            else if (TMO_EN && m_hunt == HT - 1) begin nxt = 0; m_tmo = 1; end
            m_hunt++;
         end else begin
            if (m_ncol % BIT == 0) cap = 1;
         end
         if (cap) begin
            if (!m_vld || xfer) begin m_dat = window(); m_vld = 1; m_lst = (m_words == FW - 1); end
            else m_ovf = 1;
            m_words++;
            if (m_words == FW) nxt = 0;
         end else if (xfer) begin
            m_vld = 0; m_lst = 0;
         end
         if (m_mode != 0 && !abort) begin
            hist.push_back(b);
            if (hist.size() > BIT) void'(hist.pop_front());
            if (nxt == 2) m_ncol++;
         end
         m_mode = nxt;
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         chk("cmp_en", s2p_en, m_mode != 0);
         chk("cmp_busy", busy, m_mode != 0);
         chk("cmp_locked", locked, m_mode == 2);
         chk("cmp_valid", word_valid, m_vld);
         chk("cmp_data", word_data, m_dat);
         chk("cmp_last", word_last, m_lst);
         chk("cmp_ovf", overflow, m_ovf);
         chk("cmp_tmo", timeout, m_tmo);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_word(input logic [BIT-1:0] w);
      for (int i = BIT - 1; i >= 0; i--) stream.push_back(w[i]);
   endtask

   logic [BIT-1:0] nom_w [FW] = '{10'h155, 10'h2AA, 10'h0F0, 10'h30F};

   task automatic load_nominal();
      stream.delete();
      push_word(SYNC);
      for (int i = 0; i < FW; i++) push_word(nom_w[i]);
   endtask

   task automatic clr_got();
      got_d.delete(); got_l.delete(); got_c.delete();
   endtask

   task automatic chk_nominal_words(input string nm);
      chk({nm, "_count"}, got_d.size(), FW);
      for (int i = 0; i < FW; i++) if (got_d.size() > i) begin
         chk({nm, "_data"}, got_d[i], nom_w[i]);
         chk({nm, "_last"}, got_l[i], i == FW - 1);
      end
   endtask

   int st;

   initial begin
      rst = 1; start = 0; abort = 0; word_ready = 0;
      tick(); tick();
      rst = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("idle_outs", {s2p_en, word_valid, word_last, locked, busy, overflow, timeout, word_data}, 0);
      end

      // nominal frame with a ready consumer
      load_nominal(); clr_got(); word_ready = 1;
      start = 1; tick(); st = cyc; start = 0;
      chk("nom_busy", busy, 1);
      chk("nom_en", s2p_en, 1);
      repeat (60) tick();
      chk_nominal_words("nom");
      for (int i = 0; i < FW; i++) if (got_c.size() > i) chk("nom_time", got_c[i] - st, 22 + 10 * i);
      chk("nom_idle", {busy, s2p_en, word_valid}, 0);

      // consumer stalled for the whole frame
      load_nominal(); clr_got(); word_ready = 0;
      start = 1; tick(); start = 0;
      repeat (30) tick();
      chk("bp_ovf_pre", overflow, 0);
      tick();
      chk("bp_ovf", overflow, 1);
      repeat (30) tick();
      chk("bp_hold", {word_valid, word_last, word_data}, {1'b1, 1'b0, 10'h155});
      chk("bp_busy", busy, 0);
      word_ready = 1; tick(); word_ready = 0;
      chk("bp_drain", got_d.size(), 1);
      if (got_d.size() > 0) chk("bp_word", got_d[0], 10'h155);
      chk("bp_empty", word_valid, 0);
      chk("bp_ovf_sticky", overflow, 1);

      // accept exactly on the second capture edge
      load_nominal(); clr_got(); word_ready = 0;
      start = 1; tick(); start = 0;
      chk("sim_ovf_clr", overflow, 0);
      repeat (30) tick();
      word_ready = 1; tick(); word_ready = 0;
      chk("sim_next", {word_valid, word_data}, {1'b1, 10'h2AA});
      chk("sim_ovf", overflow, 0);
      word_ready = 1; repeat (40) tick(); word_ready = 0;
      chk_nominal_words("sim");
      chk("sim_ovf_end", overflow, 0);

      // abort shortly after lock, then a clean re-hunt
      load_nominal(); clr_got(); word_ready = 1;
      start = 1; tick(); start = 0;
      repeat (12) tick();
      chk("ab_locked", locked, 1);
      abort = 1; tick(); abort = 0;
      chk("ab_idle", {busy, locked, s2p_en}, 0);
      repeat (40) tick();
      chk("ab_nowords", got_d.size(), 0);
      load_nominal(); clr_got();
      start = 1; tick(); start = 0;
      repeat (60) tick();
      chk_nominal_words("reab");

      start = 1; abort = 1; tick(); start = 0; abort = 0;
      chk("start_abort", busy, 0);

      // hunt on an all-zero stream
      stream.delete();
      start = 1; tick(); start = 0;
      repeat (63) tick();
      chk("hunt_busy63", busy, 1);
      tick();
`ifdef S2P_FRAME_CTRL_TIMEOUT_EN
      chk("tmo_idle", busy, 0);
      chk("tmo_flag", timeout, 1);
`else
      repeat (136) tick();
      chk("hunt_busy200", busy, 1);
      chk("no_tmo", timeout, 0);
      abort = 1; tick(); abort = 0;
`endif

      // randomized frames: garbage prefix, random payload, random ready/start/abort
      for (int f = 0; f < 24; f++) begin
         int ng, rm, ab;
         bit done;
         stream.delete();
         ng = $urandom_range(0, 12);
         for (int i = 0; i < ng; i++) stream.push_back(1'($urandom_range(0, 1)));
         push_word(SYNC);
         for (int i = 0; i < FW + 1; i++) push_word(10'($urandom));
         rm = $urandom_range(0, 2);
         ab = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 45) : 0;
         start = 1; tick(); start = 0;
         done = 0;
         for (int c = 1; c < 400 && !done; c++) begin
            word_ready = (rm == 0) ? 1'b1 : (rm == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 15) == 0);
            abort = (c == ab);
            tick();
            if (!busy) done = 1;
         end
         start = 0; abort = 0;
         chk("rnd_done", done, 1);
         if (!done) begin abort = 1; tick(); abort = 0; end
         word_ready = 1; repeat (2) tick(); word_ready = 0;
      end

      rst = 1; tick(); rst = 0;
      chk("final_reset", {word_valid, overflow, timeout, busy, word_data}, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
- Sequencing controller for the `s2p` serial-to-parallel shifter.
- Drives the shifter's `en`, watches its parallel `dout` for a sync word, then slices the following serial stream into BIT-bit words.
- Hands each word downstream through a one-entry valid/ready holding buffer, one frame of FRAME_WORDS words per start.
- Sits between `s2p` and the word consumer.

Parameters:
- BIT, 10, word width; must equal the width of the attached `s2p`.
- SYNC_WORD, 10'b1011001101, pattern that marks the frame start (BIT bits wide).
- FRAME_WORDS, 4, payload words per frame (range 1..255).
- HUNT_TIMEOUT, 1024, HUNT cycle limit; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock shared with `s2p`.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to arm a frame; honoured only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE.
- s2p_en  output  1  shift enable to `s2p`.
- s2p_dout  input  BIT  `s2p` parallel output.
- word_data  output  BIT  held payload word.
- word_valid  output  1  word_data valid.
- word_ready  input  1  consumer accepts; transfer when valid&ready.
- word_last  output  1  qualifies word_data as the frame's final word.
- locked  output  1  high in COLLECT.
- busy  output  1  high in HUNT or COLLECT.
- overflow  output  1  sticky: captured word dropped because the buffer was full.
- timeout  output  1  sticky hunt timeout; constant 0 without the optional feature.

Behaviour:
- `s2p` contract: shifts dext into its LSB on each rising clk while en=1; dout is its register.
- Reset (rst=1 at an edge) sets the following; the state is IDLE.
  - s2p_en=0, word_data=0, word_valid=0, word_last=0, locked=0, busy=0, overflow=0, timeout=0.
  - All counters are cleared.
- Reset mid-frame discards everything, including a pending word.
- IDLE:
  - s2p_en=0.
  - start=1 → HUNT. On this transition, fill=0, overflow=0, timeout=0.
- HUNT:
  - s2p_en=1.
  - fill increments each cycle, saturating at BIT. fill counts the shifts completed before the current cycle.
  - Match when fill==BIT and s2p_dout==SYNC_WORD → COLLECT, with cnt=1 and wcnt=0.
  - The match edge itself shifts payload bit 1.
- COLLECT:
  - s2p_en=1.
  - In a cycle with cnt==BIT, s2p_dout is a complete word → capture, and cnt<=1.
  - Otherwise cnt<=cnt+1.
  - Capture with a match in cycle t means: first capture in cycle t+BIT, word_valid high from cycle t+BIT+1, and later captures every BIT cycles.
  - Each capture increments wcnt.
  - The capture with wcnt==FRAME_WORDS-1 sets word_last with the word and moves to IDLE (s2p_en=0 next cycle).
- Capture into the holding buffer:
  - Buffer empty, or (word_valid & word_ready) in the same cycle → load word_data; word_valid=1.
  - Buffer full and word_ready=0 → new word dropped; overflow=1. wcnt still increments, so the frame length is unchanged.
- Transfer without capture: word_valid&word_ready → word_valid=0 and word_last=0 next cycle.
- word_data and word_last are stable while word_valid=1 and word_ready=0.
- abort=1 (from any state, priority over start and capture):
  - Next state IDLE, s2p_en=0.
  - The holding buffer and its valid are kept, so the consumer may still drain it.
  - Sticky flags are kept.
- start is ignored outside IDLE.
- start and abort together in IDLE → stay IDLE.
- Outputs are registered, except that locked and busy decode the state register.

Optional Feature:
- Macro: S2P_FRAME_CTRL_TIMEOUT_EN.
- When defined:
  - A hunt counter clears on entering HUNT and increments each HUNT cycle.
  - When it reaches HUNT_TIMEOUT-1 without a match → IDLE with timeout=1 (sticky until the next start or rst).
  - A match in that same cycle wins.
- When undefined:
  - No counter logic is built.
  - timeout is tied 0.
  - HUNT waits indefinitely.

Test Plan:
- Reset then idle: rst 2 cycles, no start → all outputs 0, s2p_en=0 for 50 cycles.
- Nominal frame: BIT=10, FRAME_WORDS=4, word_ready=1. start, stream SYNC_WORD then 0x155, 0x2AA, 0x0F0, 0x30F MSB-first → 4 single-cycle word_valid pulses 10 cycles apart with those values; word_last only on 0x30F; back in IDLE.
- Backpressure: word_ready=0 throughout the nominal frame → word_data=0x155 held, overflow=1 after the 2nd capture, 3rd/4th dropped; raise ready → one transfer, buffer empty.
- Simultaneous accept and capture: word_ready pulsed exactly in a capture cycle → no overflow, next word loaded without a gap.
- Abort: abort 3 cycles into COLLECT → IDLE next cycle, s2p_en=0, no further words; a new start re-hunts correctly.
- Timeout (macro defined, HUNT_TIMEOUT=64): all-zero stream → timeout=1, IDLE at cycle 64 after entering HUNT. Without the macro → still busy at cycle 200.
